// File: rtl/redmule_data_demux.sv
// Address-decoding demultiplexer for the core data port. It routes each
// request to one of N_TGT external targets, the built-in mailbox or an error
// sink. Responses come back in order because a new request is only granted
// while it goes to the same destination as the transactions still open.
//
// Handshake: a request is accepted in the cycle where req_i && gnt_o. Each
// accepted request gets exactly one rvalid_o pulse, in acceptance order.
// Target-side handshakes use the same rule: tgt_req_o[i] && tgt_gnt_i[i].
module redmule_data_demux #(
   parameter int unsigned N_TGT   = 3,
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned MAX_OUT = 4,
   parameter logic [0:N_TGT-1][AW-1:0] TGT_BASE = {32'h1c100000, 32'h00000000, 32'h1c000000},
   parameter logic [0:N_TGT-1][AW-1:0] TGT_MASK = {32'hfff00000, 32'hff000000, 32'hff000000},
   parameter logic [AW-1:0] MBOX_BASE = 32'h80000000
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [AW-1:0]       addr_i,
   input  logic [DW/8-1:0]     be_i,
   input  logic [DW-1:0]       wdata_i,
   output logic                gnt_o,
   output logic                rvalid_o,
   output logic [DW-1:0]       rdata_o,
   output logic                err_o,
   output logic [N_TGT-1:0]    tgt_req_o,
   output logic [AW-1:0]       tgt_addr_o,
   output logic                tgt_we_o,
   output logic [DW/8-1:0]     tgt_be_o,
   output logic [DW-1:0]       tgt_wdata_o,
   input  logic [N_TGT-1:0]    tgt_gnt_i,
   input  logic [N_TGT-1:0]    tgt_rvalid_i,
   input  logic [N_TGT*DW-1:0] tgt_rdata_i,
   output logic                exit_valid_o,
   output logic [31:0]         exit_code_o,
   output logic                putc_valid_o,
   output logic [7:0]          putc_char_o,
   output logic                unexp_rsp_o
);

   // Destination ids: 0..N_TGT-1 targets, then mailbox, then error sink.
   localparam int unsigned DID_W = $clog2(N_TGT + 2);
   localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
   localparam logic [DID_W-1:0] ID_MBOX = DID_W'(N_TGT);
   localparam logic [DID_W-1:0] ID_ERR  = DID_W'(N_TGT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
   logic [DID_W-1:0] cur_q, cur_d, sel;
   logic             int_vld_q, int_vld_d;
   logic             int_err_q, int_err_d;
   logic [DW-1:0]    int_rdata_q, int_rdata_d;
   logic [31:0]      exit_code_q, exit_code_d;
   logic             exit_valid_q, exit_valid_d;
   logic             putc_valid_q, putc_valid_d;
   logic [7:0]       putc_char_q, putc_char_d;
   logic [DW-1:0]    scratch_q, scratch_d;
   logic [31:0]      cycles_q, cycles_d;
   logic             unexp_q, unexp_d;

   logic             found, stall, go, cur_int, rsp_vld, tgt_rv_cur, mb_gnt;
   logic [DW-1:0]    tgt_rd_cur;

   assign tgt_addr_o  = addr_i;
   assign tgt_we_o    = we_i;
   assign tgt_be_o    = be_i;
   assign tgt_wdata_o = wdata_i;

   assign exit_valid_o = exit_valid_q;
   assign exit_code_o  = exit_code_q;
   assign putc_valid_o = putc_valid_q;
   assign putc_char_o  = putc_char_q;
   assign unexp_rsp_o  = unexp_q;

   // Decode: mailbox wins, then the lowest matching target, else error sink.
   always_comb begin
      sel   = ID_ERR;
      found = 1'b0;
      if (addr_i[AW-1:4] == MBOX_BASE[AW-1:4]) begin
         sel   = ID_MBOX;
         found = 1'b1;
      end
      for (int i = 0; i < N_TGT; i++) begin
         if (!found && ((addr_i & TGT_MASK[i]) == TGT_BASE[i])) begin
            sel   = DID_W'(i);
            found = 1'b1;
         end
      end
   end

   // Response path: only the current destination may answer.
   always_comb begin
      tgt_rv_cur = 1'b0;
      tgt_rd_cur = '0;
      for (int j = 0; j < N_TGT; j++) begin
         if (cur_q == DID_W'(j)) begin
            tgt_rv_cur = tgt_rvalid_i[j];
            tgt_rd_cur = tgt_rdata_i[j*DW +: DW];
         end
      end
      cur_int  = (cur_q == ID_MBOX) || (cur_q == ID_ERR);
      rsp_vld  = (cnt_q != '0) && (cur_int ? int_vld_q : tgt_rv_cur);
      rvalid_o = rsp_vld;
      rdata_o  = rsp_vld ? (cur_int ? int_rdata_q : tgt_rd_cur) : '0;
      err_o    = rsp_vld && cur_int && int_err_q;
   end

   // Grant: a response retiring this cycle frees its slot for a new grant,
   // so a saturated or switching port loses no cycle.
   always_comb begin
      cnt_eff   = cnt_q - CNT_W'(rsp_vld);
      stall     = (cnt_eff == CNT_W'(MAX_OUT)) || ((cnt_eff != '0) && (sel != cur_q));
      go        = req_i && !stall;
      tgt_req_o = '0;
      gnt_o     = 1'b0;
      for (int i = 0; i < N_TGT; i++) begin
         if (sel == DID_W'(i)) begin
            tgt_req_o[i] = go;
            gnt_o        = go && tgt_gnt_i[i];
         end
      end
      if ((sel == ID_MBOX) || (sel == ID_ERR)) gnt_o = go;
   end

   // Next state: ordering counter, mailbox registers, internal response.
   always_comb begin
      mb_gnt       = gnt_o && (sel == ID_MBOX);
      cnt_d        = cnt_q + CNT_W'(gnt_o) - CNT_W'(rsp_vld);
      cur_d        = gnt_o ? sel : cur_q;
      int_vld_d    = gnt_o && ((sel == ID_MBOX) || (sel == ID_ERR));
      int_err_d    = gnt_o && (sel == ID_ERR);
      int_rdata_d  = '0;
      exit_code_d  = exit_code_q;
      exit_valid_d = exit_valid_q;
      putc_valid_d = 1'b0;
      putc_char_d  = putc_char_q;
      scratch_d    = scratch_q;
      cycles_d     = cycles_q + 32'd1;
      unexp_d      = unexp_q;
      if (mb_gnt && !we_i) begin
         case (addr_i[3:2])
            2'd0:    int_rdata_d = DW'(exit_code_q);
            2'd2:    int_rdata_d = DW'(cycles_q);
            2'd3:    int_rdata_d = scratch_q;
            default: int_rdata_d = '0;
         endcase
      end
      if (mb_gnt && we_i) begin
         case (addr_i[3:2])
            2'd0: begin
               exit_code_d  = wdata_i[31:0];
               exit_valid_d = 1'b1;
            end
            2'd1: begin
               putc_valid_d = 1'b1;
               putc_char_d  = wdata_i[7:0];
            end
            2'd3: begin
               for (int b = 0; b < DW/8; b++) begin
                  if (be_i[b]) scratch_d[b*8 +: 8] = wdata_i[b*8 +: 8];
               end
            end
            default: ;
         endcase
      end
      for (int j = 0; j < N_TGT; j++) begin
         if (tgt_rvalid_i[j] && ((cnt_q == '0) || (cur_q != DID_W'(j)))) unexp_d = 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q        <= '0;
         cur_q        <= ID_ERR;
         int_vld_q    <= 1'b0;
         int_err_q    <= 1'b0;
         int_rdata_q  <= '0;
         exit_code_q  <= 32'hFFFFFFFF;
         exit_valid_q <= 1'b0;
         putc_valid_q <= 1'b0;
         putc_char_q  <= 8'h00;
         scratch_q    <= '0;
         cycles_q     <= 32'd0;
         unexp_q      <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         cur_q        <= cur_d;
         int_vld_q    <= int_vld_d;
         int_err_q    <= int_err_d;
         int_rdata_q  <= int_rdata_d;
         exit_code_q  <= exit_code_d;
         exit_valid_q <= exit_valid_d;
         putc_valid_q <= putc_valid_d;
         putc_char_q  <= putc_char_d;
         scratch_q    <= scratch_d;
         cycles_q     <= cycles_d;
         unexp_q      <= unexp_d;
      end
   end

endmodule

// File: doc/redmule_data_demux.md
# redmule_data_demux

Parametrised address-decoding demultiplexer for the core's data port in the RedMulE simulation environment. It replaces hand-written priority muxing with a generic N-target router that tracks outstanding transactions and returns responses in order. It also hosts a built-in mailbox holding the exit code, putchar, cycle counter and scratch registers. It sits between `cv32e40p_core` data signals and the HWPE periph, stack and TCDM memory ports.

## Interface
- `N_TGT`, 3: number of external targets (periph, stack, TCDM by default).
- `AW`, 32: address width.
- `DW`, 32: data width; byte enables are `DW/8`.
- `MAX_OUT`, 4: maximum outstanding granted-but-unanswered transactions (≥1).
- `TGT_BASE`, `{32'h1c100000, 32'h00000000, 32'h1c000000}`: per-target base addresses.
- `TGT_MASK`, `{32'hfff00000, 32'hff000000, 32'hff000000}`: per-target address masks.
- `MBOX_BASE`, 32'h80000000: mailbox base; the mailbox decodes `addr[AW-1:4] == MBOX_BASE[AW-1:4]`.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_i`, `we_i` in 1; `addr_i` in AW; `be_i` in DW/8; `wdata_i` in DW: core request.
- `gnt_o` out 1; `rvalid_o` out 1; `rdata_o` out DW; `err_o` out 1: core handshake and response.
- `tgt_req_o` out N_TGT: one-hot target request.
- `tgt_addr_o`, `tgt_we_o`, `tgt_be_o`, `tgt_wdata_o` out: broadcast copies of the core request.
- `tgt_gnt_i`, `tgt_rvalid_i` in N_TGT; `tgt_rdata_i` in N_TGT×DW: target handshake and response.
- `exit_valid_o` out 1; `exit_code_o` out 32: end-of-test indication.
- `putc_valid_o` out 1; `putc_char_o` out 8: character output.
- `unexp_rsp_o` out 1: sticky protocol-error flag.

## Operation
- **Decode priority:** mailbox first, then the lowest index `i` with `(addr_i & TGT_MASK[i]) == TGT_BASE[i]`; otherwise the request goes to the error sink.
- **Mailbox registers** (offset `addr_i[3:2]`):
  - 0 EXIT: a write loads `exit_code_o` and sets sticky `exit_valid_o`. A read returns `exit_code_o`.
  - 1 PUTC: a write drives `putc_char_o = wdata_i[7:0]` and pulses `putc_valid_o` for 1 cycle. A read returns 0.
  - 2 CYCLES: read-only, free-running 32-bit counter that wraps. Writes are ignored.
  - 3 SCRATCH: read/write, with byte-enables honoured.
- **Error sink:** grants immediately and responds with `err_o=1` and `rdata_o=0`. Writes have no side effect.
- **Every granted request gets exactly one rvalid**, writes included.
- **Ordering state:** an outstanding counter `cnt` (0..MAX_OUT) and the destination id `cur` (N_TGT+2 encodings: targets, mailbox, error sink).
- **Stall conditions:** a new request stalls (`tgt_req_o=0`, `gnt_o=0`) when `cnt==MAX_OUT`, or when `cnt!=0` and the decoded destination differs from `cur`. This guarantees in-order responses without reorder storage.
- **Response path:** `rvalid_o`/`rdata_o` are taken only from `cur`.
  - `tgt_rvalid_i[j]` with `j!=cur` or with `cnt==0` sets `unexp_rsp_o` and is dropped.
- **Counter update:** `cnt` increments on grant and decrements on `rvalid_o`; both in the same cycle leave it unchanged.

## Timing
- **Decode and grant are combinational:** `gnt_o = tgt_gnt_i[sel]` for targets and `1` for mailbox or error sink, qualified by the absence of a stall.
- **Target response latency** is whatever the target provides; pass-through is combinational, zero added cycles.
- **Mailbox and error-sink responses** assert `rvalid_o` exactly 1 cycle after grant. Mailbox write effects are visible on outputs in that same cycle.
- **Back-to-back:** successive mailbox requests are granted every cycle, giving full throughput.
- **Reset values:**
  - `gnt_o`, `rvalid_o`, `err_o`, `tgt_req_o`, `putc_valid_o`, `exit_valid_o`, `unexp_rsp_o` = 0.
  - `rdata_o` = 0; `putc_char_o` = 0; `exit_code_o` = 32'hFFFFFFFF.
  - CYCLES = 0; SCRATCH = 0; `cnt` = 0.
- **Reset mid-transaction:** `cnt` clears and pending responses are discarded. Target rvalids arriving after reset set `unexp_rsp_o`; this is expected, and the bench tolerates it.
- **CYCLES** increments every non-reset cycle and wraps 32'hFFFFFFFF→0.

## Test plan
- **Mailbox exit:** write 0x0000_0000 to 0x8000_0000 → grant same cycle, `rvalid_o` next cycle, `exit_valid_o=1`, `exit_code_o=0`. After reset, `exit_code_o` reads 0xFFFFFFFF.
- **Putchar:** write 0x41 then 0x0A to 0x8000_0004 in back-to-back cycles → two 1-cycle `putc_valid_o` pulses with chars 0x41 and 0x0A, and two rvalids.
- **Ordering stall:** `MAX_OUT=4`, TCDM responds with 3-cycle latency. Issue a load to 0x1c010000, then a load to 0x0000_1000 → the stack request is held with `gnt_o=0` until the TCDM rvalid, then granted. Responses arrive in order.
- **Saturation:** 5 consecutive TCDM loads with the target withholding rvalid → 4 grants, the 5th stalls. The next rvalid and the 5th grant occur in the same cycle and `cnt` stays at 4.
- **Unmapped access:** load from 0x4000_0000 → grant, next-cycle rvalid with `err_o=1` and `rdata_o=0`. A spurious `tgt_rvalid_i[1]` with `cnt==0` sets `unexp_rsp_o`, which stays set until reset.
- **Scratch/cycles:** write 0xA5A5A5A5 with `be=4'b0011` to offset 0xC, then read → 0x0000A5A5. Two CYCLES reads N cycles apart differ by N.
